conv3x3_window_sched: RTL

- Sequences a raster-scan 8-bit pixel stream into 3x3 neighbourhoods for the team's combinational 3x3 kernel blocks (line/edge detectors with 9 pixel inputs p1..p9).
- Holds two internal line buffers and a 3x3 shift window.
- Emits only windows lying fully inside the image, with valid/ready handshakes on both sides.
- Runs one frame per start pulse and reports frame completion.

---
 rtl/conv3x3_window_sched_if.sv | 29 ++
 rtl/conv3x3_window_sched.sv | 124 ++++++++++++
 2 files changed

// File: rtl/conv3x3_window_sched_if.sv
// Pixel-in / 3x3-window-out handshake bundle for conv3x3_window_sched.
// master drives pixels and frame start; slave is the window scheduler.
interface conv3x3_window_sched_if #(
  parameter int CW = 10
);
  logic          start;
  logic          busy;
  logic          frame_done;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_pix;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;

  modport master (
    output start, in_valid, in_pix, out_ready,
    input  busy, frame_done, in_ready, out_valid,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9, out_row, out_col
  );

  modport slave (
    input  start, in_valid, in_pix, out_ready,
    output busy, frame_done, in_ready, out_valid,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9, out_row, out_col
  );
endinterface

// File: rtl/conv3x3_window_sched.sv
// Raster pixel stream -> interior 3x3 windows; one-cycle registered latency.
// A held window (out_valid & !out_ready) stalls pixel intake; windows stream back-to-back otherwise.
module conv3x3_window_sched #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  conv3x3_window_sched_if.slave bus
);
  localparam int AW = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, LAST, DONE} state_t;

  state_t        state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [7:0]    lb_top [IMG_W];
  logic [7:0]    lb_mid [IMG_W];
  logic [7:0]    win    [9];
  logic [AW-1:0] addr;
  logic [7:0]    up_top;
  logic [7:0]    up_mid;
  logic          xfer;
  logic          emit;
  logic          at_last;

  assign bus.in_ready = ((state == FILL) || (state == RUN)) && (!bus.out_valid || bus.out_ready);
  assign xfer    = bus.in_valid && bus.in_ready;
  assign addr    = col[AW-1:0];
  assign up_top  = lb_top[addr];
  assign up_mid  = lb_mid[addr];
  assign emit    = (row >= TWO) && (col >= TWO);
  assign at_last = (row == LAST_ROW) && (col == LAST_COL);

  // The window registers are the outputs; they only move on a transfer, so a stall holds them.
  assign bus.p1 = win[0];
  assign bus.p2 = win[1];
  assign bus.p3 = win[2];
  assign bus.p4 = win[3];
  assign bus.p5 = win[4];
  assign bus.p6 = win[5];
  assign bus.p7 = win[6];
  assign bus.p8 = win[7];
  assign bus.p9 = win[8];

  // Per column: top holds row-2, mid holds row-1 relative to the incoming pixel.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb_top[addr] <= up_mid;
      lb_mid[addr] <= bus.in_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      row            <= '0;
      col            <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_row    <= '0;
      bus.out_col    <= '0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= FILL;
            row      <= '0;
            col      <= '0;
            bus.busy <= 1'b1;
          end
        end
        FILL, RUN: begin
          if (xfer) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= up_top;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= up_mid;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= bus.in_pix;
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + ONE;
            end else begin
              col <= col + ONE;
            end
            bus.out_valid <= emit;
            if (emit) begin
              bus.out_row <= row - ONE;
              bus.out_col <= col - ONE;
            end
            // A 3x3 image ends on the same pixel that completes the fill.
            if (at_last) state <= LAST;
            else if ((row == TWO) && (col == TWO)) state <= RUN;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
        end
        LAST: begin
          if (!bus.out_valid || bus.out_ready) begin
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b1;
            state          <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
